barrel_shifter: RTL and testbench
=================================

Name: barrel_shifter

Overview:
- Registered, logarithmic barrel shifter used by the datapath for variable shifts and rotates.
- Shifts a WIDTH-bit operand by a runtime amount in one pass: log2(WIDTH) mux stages, each stage selected by one amount bit.
- Result and status are registered: one-cycle latency, with valid tracking.
- Default op (logical right shift) gives a >> b.

Parameters:
- WIDTH, 8, operand/result width in bits; must be a power of two, at least 2.
- SHAMT_W, $clog2(WIDTH) (3 at default), shift-amount width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operands valid this cycle; result captured on this edge.
- a  input  WIDTH  operand to shift.
- b  input  SHAMT_W  shift amount, unsigned, 0..WIDTH-1.
- op  input  2  operation: 00 SRL, 01 SLL, 10 SRA, 11 ROR.
- o  output  WIDTH  registered result.
- out_valid  output  1  o is valid; registered copy of in_valid.
- zero  output  1  registered flag, 1 when the result captured with o is all zeros.

Behaviour:
- Reset: on a rising clk edge with rst=1, o=0, out_valid=0 and zero=0.
  - Reset has priority over in_valid.
  - A reset in the same cycle as in_valid drops that operation.
- Latency: inputs sampled on edge N when in_valid=1; o, zero and out_valid=1 appear after edge N.
- Throughput: one operation per cycle, no stall or backpressure.
- in_valid=0: out_valid goes 0 on the next edge; o and zero hold their last values.
- SRL (00): o = a >> b, zero-filled from the MSB side.
- SLL (01): o = a << b, zero-filled from the LSB side.
- SRA (10): o = a >>> b, filled with a[WIDTH-1].
- ROR (11): o = {a, a} >> b, low WIDTH bits; bits leaving the LSB re-enter at the MSB.
- b=0: o=a for every op.
- b=WIDTH-1:
  - SRL: o = {0..0, a[WIDTH-1]}.
  - SLL: o = {a[0], 0..0}.
  - SRA: o is all copies of the sign bit.
- Amounts ≥ WIDTH cannot occur, since b is SHAMT_W bits wide.
- Structure:
  - SHAMT_W cascaded stages; stage k shifts by 2^k when b[k]=1.
  - Left shift is done by bit-reversing the input and output around the right-shift network.
  - All logic before the output register is combinational; no multipliers, no variable-index loops.
- Inputs are not registered. X on a or b with in_valid=0 must not affect o.

Optional Feature:
- Macro: BARREL_SHIFTER_ROTATE_EN.
- Defined: op 11 performs ROR as specified above.
- Undefined:
  - The rotate fill path is not built; op 11 is decoded as SRL.
  - For example, a=0x01, b=1, op=11 gives o=0x00 and zero=1.
- All other ops are identical with or without the macro.

Test Plan:
- SRL, one in_valid pulse per row, check o one cycle after each: a=0x10 b=4 -> 0x01; a=0x04 b=2 -> 0x01; a=0x02 b=1 -> 0x01; a=0x80 b=7 -> 0x01; out_valid=1 each cycle after a pulse, zero=0.
- SLL/SRA: a=0x01 b=7 op=01 -> o=0x80. a=0x80 b=7 op=10 -> o=0xFF. a=0x40 b=3 op=10 -> o=0x08. a=0x5A b=0 any op -> o=0x5A.
- ROR with BARREL_SHIFTER_ROTATE_EN: a=0x01 b=1 -> 0x80; a=0x81 b=4 -> 0x18. Without the macro: a=0x01 b=1 op=11 -> o=0x00, zero=1.
- Zero flag and hold: a=0x01 b=1 op=00 -> o=0x00, zero=1. Then in_valid=0 with random a/b -> out_valid=0, o and zero unchanged.
- Back-to-back: eight consecutive in_valid cycles with b=0..7 on a=0xFF SRL -> o=0xFF, 0x7F, …, 0x01 on consecutive cycles.
- Reset: assert rst in the same cycle as in_valid with a=0xFF -> next cycle o=0x00, out_valid=0, zero=0. Deassert rst -> normal operation resumes on the next pulse.

Source files
------------

// File: rtl/barrel_shifter.sv
// Registered logarithmic barrel shifter: SRL, SLL, SRA and (with BARREL_SHIFTER_ROTATE_EN) ROR.
// Without BARREL_SHIFTER_ROTATE_EN the rotate fill path is absent and op 11 behaves as SRL.
module barrel_shifter #(
    parameter int WIDTH   = 8,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   a,
    input  logic [SHAMT_W-1:0] b,
    input  logic [1:0]         op,
    output logic [WIDTH-1:0]   o,
    output logic               out_valid,
    output logic               zero
);

    logic             left;
    logic             fill;
    logic [WIDTH-1:0] a_rev;
    logic [WIDTH-1:0] net_in;
    logic [WIDTH-1:0] net_out;
    logic [WIDTH-1:0] net_out_rev;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] stage [SHAMT_W+1];

    assign left = (op == 2'b01);
    assign fill = (op == 2'b10) & a[WIDTH-1];

`ifdef BARREL_SHIFTER_ROTATE_EN
    logic rotate;
    assign rotate = (op == 2'b11);
`endif

    // Left shifts reuse the right-shift network by mirroring the operand around it.
    for (genvar i = 0; i < WIDTH; i++) begin : g_rev
        assign a_rev[i]       = a[WIDTH-1-i];
        assign net_out_rev[i] = net_out[WIDTH-1-i];
    end

    assign net_in   = left ? a_rev : a;
    assign stage[0] = net_in;

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        localparam int S = 1 << k;
        logic [S-1:0] hi;
`ifdef BARREL_SHIFTER_ROTATE_EN
        assign hi = rotate ? stage[k][S-1:0] : {S{fill}};
`else
        assign hi = {S{fill}};
`endif
        assign stage[k+1] = b[k] ? {hi, stage[k][WIDTH-1:S]} : stage[k];
    end

    assign net_out = stage[SHAMT_W];
    assign result  = left ? net_out_rev : net_out;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            o         <= '0;
            out_valid <= 1'b0;
            zero      <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                o    <= result;
                zero <= (result == '0);
            end
        end
    end

endmodule

// File: tb/tb_barrel_shifter.sv
// Self-checking bench for barrel_shifter (WIDTH=8) against an operator-level reference model.
module tb_barrel_shifter;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] a;
    logic [2:0] b;
    logic [1:0] op;
    logic [7:0] o;
    logic       out_valid;
    logic       zero;

    int tests = 0;
    int fails = 0;

    logic [7:0] exp_o;
    logic       exp_v;
    logic       exp_z;

    barrel_shifter #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .op       (op),
        .o        (o),
        .out_valid(out_valid),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_model(input logic [7:0] x, input int sh, input logic [1:0] f);
        logic [15:0] dbl;
        logic [7:0]  r;
        dbl = {x, x} >> sh;
        case (f)
            2'b00: r = x >> sh;
            2'b01: r = x << sh;
            2'b10: r = $signed(x) >>> sh;
`ifdef BARREL_SHIFTER_ROTATE_EN
            default: r = dbl[7:0];
`else
            default: r = x >> sh;
`endif
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Drive one cycle, update the expected registered state, then check after the edge.
    task automatic step(input string tag, input logic r, input logic v,
                        input logic [7:0] x, input logic [2:0] sh, input logic [1:0] f);
        rst      = r;
        in_valid = v;
        a        = x;
        b        = sh;
        op       = f;
        if (r) begin
            exp_o = 8'h00;
            exp_v = 1'b0;
            exp_z = 1'b0;
        end else begin
            exp_v = v;
            if (v) begin
                exp_o = ref_model(x, int'(sh), f);
                exp_z = (exp_o == 8'h00);
            end
        end
        @(posedge clk);
        #1;
        check({tag, ".o"}, o, exp_o);
        check({tag, ".valid"}, {7'd0, out_valid}, {7'd0, exp_v});
        check({tag, ".zero"}, {7'd0, zero}, {7'd0, exp_z});
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = 8'h00; b = 3'd0; op = 2'b00;
        exp_o = 8'h00; exp_v = 1'b0; exp_z = 1'b0;

        step("reset0", 1'b1, 1'b0, 8'hA5, 3'd2, 2'b00);
        step("reset1", 1'b1, 1'b1, 8'h3C, 3'd1, 2'b01);

        // SRL rows, with literal expectations alongside the model
        step("srl_10_4", 1'b0, 1'b1, 8'h10, 3'd4, 2'b00); check("lit_srl_10_4", o, 8'h01);
        step("srl_04_2", 1'b0, 1'b1, 8'h04, 3'd2, 2'b00); check("lit_srl_04_2", o, 8'h01);
        step("srl_02_1", 1'b0, 1'b1, 8'h02, 3'd1, 2'b00); check("lit_srl_02_1", o, 8'h01);
        step("srl_80_7", 1'b0, 1'b1, 8'h80, 3'd7, 2'b00); check("lit_srl_80_7", o, 8'h01);

        // SLL / SRA boundaries and b=0
        step("sll_01_7", 1'b0, 1'b1, 8'h01, 3'd7, 2'b01); check("lit_sll_01_7", o, 8'h80);
        step("sra_80_7", 1'b0, 1'b1, 8'h80, 3'd7, 2'b10); check("lit_sra_80_7", o, 8'hFF);
        step("sra_40_3", 1'b0, 1'b1, 8'h40, 3'd3, 2'b10); check("lit_sra_40_3", o, 8'h08);
        for (int f = 0; f < 4; f++) begin
            step("b0", 1'b0, 1'b1, 8'h5A, 3'd0, 2'(f));
            check("lit_b0", o, 8'h5A);
        end

        // Rotate, or its SRL fallback
`ifdef BARREL_SHIFTER_ROTATE_EN
        step("ror_01_1", 1'b0, 1'b1, 8'h01, 3'd1, 2'b11); check("lit_ror_01_1", o, 8'h80);
        step("ror_81_4", 1'b0, 1'b1, 8'h81, 3'd4, 2'b11); check("lit_ror_81_4", o, 8'h18);
`else
        step("op11_01_1", 1'b0, 1'b1, 8'h01, 3'd1, 2'b11); check("lit_op11_01_1", o, 8'h00);
        check("lit_op11_zero", {7'd0, zero}, 8'h01);
`endif

        // Zero flag then hold while idle
        step("zero_01_1", 1'b0, 1'b1, 8'h01, 3'd1, 2'b00); check("lit_zero_flag", {7'd0, zero}, 8'h01);
        for (int i = 0; i < 3; i++)
            step("hold", 1'b0, 1'b0, 8'($urandom), 3'($urandom), 2'($urandom));
        check("lit_hold_o", o, 8'h00);

        // Back-to-back SRL of 0xFF
        for (int s = 0; s < 8; s++) begin
            step("b2b", 1'b0, 1'b1, 8'hFF, 3'(s), 2'b00);
            check("lit_b2b", o, 8'(16'h00FF >> s));
        end

        // Reset colliding with a valid operation, then recovery
        step("rst_drop", 1'b1, 1'b1, 8'hFF, 3'd0, 2'b00); check("lit_rst_o", o, 8'h00);
        step("rst_idle", 1'b0, 1'b0, 8'hFF, 3'd0, 2'b00);
        step("rst_resume", 1'b0, 1'b1, 8'hF0, 3'd4, 2'b00); check("lit_resume", o, 8'h0F);

        // Randomized operations, including idle cycles
        for (int i = 0; i < 300; i++)
            step("rand", 1'b0, ($urandom_range(0, 3) != 0), 8'($urandom), 3'($urandom), 2'($urandom));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
